// File: rtl/scoreboard_pkg.sv
// Shared scoreboard definitions: game-clock FSM state encodings, BCD digit
// geometry and digit-limit constants. Imported by game_timer and reused by
// the shot clock.
package scoreboard_pkg;

   localparam int          DIGIT_W    = 4;
   localparam int          BUZZ_CNT_W = 27;
   localparam logic [15:0] TIME_ZERO  = 16'h0000;
   localparam logic [3:0]  DIGIT_MAX  = 4'd9;   // largest BCD digit
   localparam logic [3:0]  TENS_MAX   = 4'd5;   // largest seconds-tens digit

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

endpackage

// File: rtl/tick_edge_detect.sv
// Synchronizes the slow divided clock into the clk domain and emits a
// one-cycle tick per sclk_in rising edge. The tick is registered, so it
// asserts on the 3rd clk edge after sclk_in rises. Falling edges are ignored.
// Ports:
//   clk      in  system clock
//   reset    in  async, active-high
//   sclk_in  in  asynchronous slow square wave
//   tick     out one-cycle pulse per rising edge of sclk_in
module tick_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic sclk_in,
   output logic tick
);

   logic [1:0] sync_q;   // [0] first (metastable) stage, [1] second stage
   logic       prev_q;   // previous synchronized level

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b00;
         prev_q <= 1'b0;
         tick   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], sclk_in};
         prev_q <= sync_q[1];
         tick   <= sync_q[1] & ~prev_q;
      end
   end

endmodule

// File: rtl/game_timer.sv
// Countdown game clock (MM:SS in BCD) for the basketball scoreboard.
// sclk_in ticks are prescaled to one-second strobes while running and the
// period counts down to 00:00. Priority each cycle: load > stop > start > strobe.
// Optional build macro GAME_TIMER_BUZZER_EN adds the end-of-period horn
// (buzzer high for BUZZ_CYCLES clk cycles on entry to EXPIRED).
// Ports:
//   clk, reset (async active-high), sclk_in (async slow clock)
//   start/stop  level run/pause requests, load/load_value BCD preset
//   time_bcd    current time {min_tens,min_ones,sec_tens,sec_ones}
//   running, expired  decoded from registered state; buzzer  horn output
module game_timer
   import scoreboard_pkg::*;
#(
   parameter int          TICKS_PER_SEC = 1,
   parameter logic [15:0] DEFAULT_TIME  = 16'h1200,
   parameter int          BUZZ_CYCLES   = 50000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sclk_in,
   input  logic        start,
   input  logic        stop,
   input  logic        load,
   input  logic [15:0] load_value,
   output logic [15:0] time_bcd,
   output logic        running,
   output logic        expired,
   output logic        buzzer
);

   localparam logic [7:0] PRESC_LAST = 8'(TICKS_PER_SEC - 1);

   // Clamp out-of-range digits: any digit >9 -> 9, seconds tens >5 -> 5.
   function automatic logic [15:0] bcd_sanitize(input logic [15:0] v);
      logic [15:0]        r;
      logic [DIGIT_W-1:0] d;
      logic [DIGIT_W-1:0] lim;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         d   = v[i*DIGIT_W +: DIGIT_W];
         lim = (i == 1) ? TENS_MAX : DIGIT_MAX;
         r[i*DIGIT_W +: DIGIT_W] = (d > lim) ? lim : d;
      end
      return r;
   endfunction

   // One-second BCD decrement with borrow chain; saturates at 00:00.
   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [DIGIT_W-1:0] s1, s10, m1, m10;
      {m10, m1, s10, s1} = v;
      if (v != TIME_ZERO) begin
         if (s1 != 4'd0) s1 = s1 - 4'd1;
         else begin
            s1 = DIGIT_MAX;
            if (s10 != 4'd0) s10 = s10 - 4'd1;
            else begin
               s10 = TENS_MAX;
               if (m1 != 4'd0) m1 = m1 - 4'd1;
               else begin
                  m1  = DIGIT_MAX;
                  m10 = m10 - 4'd1;
               end
            end
         end
      end
      return {m10, m1, s10, s1};
   endfunction

   state_t      state, state_nxt;
   logic [15:0] time_q, time_nxt;
   logic [7:0]  presc_q, presc_nxt;
   logic        tick;
   logic        sec_strobe;

   tick_edge_detect u_tick (
      .clk     (clk),
      .reset   (reset),
      .sclk_in (sclk_in),
      .tick    (tick)
   );

   // A strobe only counts when nothing of higher priority is pending.
   assign sec_strobe = tick && (state == ST_RUN) && !load && !stop &&
                       (presc_q == PRESC_LAST);

   always_comb begin
      state_nxt = state;
      time_nxt  = time_q;
      presc_nxt = presc_q;
      if (load) begin
         time_nxt  = bcd_sanitize(load_value);
         presc_nxt = '0;
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!stop && start && (time_q != TIME_ZERO)) begin
                  state_nxt = ST_RUN;
                  presc_nxt = '0;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state_nxt = ST_PAUSE;
               end else if (sec_strobe) begin
                  presc_nxt = '0;
                  time_nxt  = bcd_dec(time_q);
                  if (time_nxt == TIME_ZERO) state_nxt = ST_EXPIRED;
               end else if (tick) begin
                  presc_nxt = presc_q + 8'd1;
               end
            end
            ST_PAUSE: begin
               // prescaler is held so a resume keeps the partial second
               if (!stop && start) state_nxt = ST_RUN;
            end
            default: ;  // EXPIRED: holds at 00:00 until load or reset
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         time_q  <= DEFAULT_TIME;
         presc_q <= '0;
      end else begin
         state   <= state_nxt;
         time_q  <= time_nxt;
         presc_q <= presc_nxt;
      end
   end

   assign time_bcd = time_q;
   assign running  = (state == ST_RUN);
   assign expired  = (state == ST_EXPIRED);

`ifdef GAME_TIMER_BUZZER_EN
   localparam logic [BUZZ_CNT_W-1:0] BUZZ_LEN = BUZZ_CNT_W'(BUZZ_CYCLES);

   logic [BUZZ_CNT_W-1:0] buzz_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buzz_cnt <= '0;
      end else if (load) begin
         buzz_cnt <= '0;
      end else if ((state != ST_EXPIRED) && (state_nxt == ST_EXPIRED)) begin
         buzz_cnt <= BUZZ_LEN;
      end else if (buzz_cnt != '0) begin
         buzz_cnt <= buzz_cnt - 1'b1;
      end
   end

   assign buzzer = (buzz_cnt != '0);
`else
   assign buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer.sv
module tb_game_timer;

   localparam int BUZZ = 8;
`ifdef GAME_TIMER_BUZZER_EN
   localparam bit BUZZ_ON = 1'b1;
`else
   localparam bit BUZZ_ON = 1'b0;
`endif

   // behavioural modes for the reference model
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sclk_in = 1'b0;
   logic        start = 1'b0, stop = 1'b0, load = 1'b0;
   logic [15:0] load_value = 16'h0000;
   logic [15:0] time_o [2];
   logic        run_o [2], exp_o [2], buz_o [2];

   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   game_timer #(.TICKS_PER_SEC(1), .BUZZ_CYCLES(BUZZ)) u1 (
      .clk(clk), .reset(reset), .sclk_in(sclk_in), .start(start), .stop(stop),
      .load(load), .load_value(load_value), .time_bcd(time_o[0]),
      .running(run_o[0]), .expired(exp_o[0]), .buzzer(buz_o[0]));

   game_timer #(.TICKS_PER_SEC(4), .BUZZ_CYCLES(BUZZ)) u4 (
      .clk(clk), .reset(reset), .sclk_in(sclk_in), .start(start), .stop(stop),
      .load(load), .load_value(load_value), .time_bcd(time_o[1]),
      .running(run_o[1]), .expired(exp_o[1]), .buzzer(buz_o[1]));

   // reference model: time as plain seconds, one entry per instance
   int m_tps [2] = '{1, 4};
   int m_t [2], m_mode [2], m_cnt [2], m_bz_at [2];
   bit m_bz_v [2];
   bit h [5];          // sclk_in as seen at the last five clk edges
   int cyc = 0;
   int bz_high0 = 0;

   function automatic int to_sec(input logic [15:0] v);
      int d [4];
      for (int i = 0; i < 4; i++) begin
         d[i] = int'(v[i*4 +: 4]);
         if (d[i] > 9) d[i] = 9;
      end
      if (d[1] > 5) d[1] = 5;
      return (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
   endfunction

   function automatic logic [15:0] to_bcd(input int t);
      int mm, ss;
      mm = t / 60;
      ss = t % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_t[i] = 12 * 60; m_mode[i] = M_IDLE; m_cnt[i] = 0; m_bz_v[i] = 1'b0;
      end
      for (int k = 0; k < 5; k++) h[k] = 1'b0;
   endtask

   task automatic model_edge();
      bit tk;
      cyc++;
      for (int k = 4; k > 0; k--) h[k] = h[k-1];
      h[0] = sclk_in;
      tk = h[3] && !h[4];   // rise seen 3 edges ago becomes the tick used now
      for (int i = 0; i < 2; i++) begin
         if (load) begin
            m_t[i] = to_sec(load_value); m_cnt[i] = 0; m_mode[i] = M_IDLE;
            m_bz_v[i] = 1'b0;
         end else if (m_mode[i] == M_IDLE) begin
            if (!stop && start && m_t[i] != 0) begin m_mode[i] = M_RUN; m_cnt[i] = 0; end
         end else if (m_mode[i] == M_RUN) begin
            if (stop) m_mode[i] = M_PAUSE;
            else if (tk) begin
               m_cnt[i]++;
               if (m_cnt[i] == m_tps[i]) begin
                  m_cnt[i] = 0;
                  m_t[i]--;
                  if (m_t[i] == 0) begin
                     m_mode[i] = M_EXP; m_bz_v[i] = 1'b1; m_bz_at[i] = cyc;
                  end
               end
            end
         end else if (m_mode[i] == M_PAUSE) begin
            if (!stop && start) m_mode[i] = M_RUN;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d.time", i), time_o[i], to_bcd(m_t[i]));
         chk($sformatf("u%0d.running", i), 16'(run_o[i]), 16'(m_mode[i] == M_RUN));
         chk($sformatf("u%0d.expired", i), 16'(exp_o[i]), 16'(m_mode[i] == M_EXP));
         chk($sformatf("u%0d.buzzer", i), 16'(buz_o[i]),
             16'(BUZZ_ON && m_bz_v[i] && (cyc - m_bz_at[i]) < BUZZ));
      end
   endtask

   // one clock: drive at negedge, model at posedge, sample #1 later
   task automatic step(input logic st, input logic sp, input logic ld,
                       input logic [15:0] lv);
      start = st; stop = sp; load = ld; load_value = lv;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      if (buz_o[0]) bz_high0++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic sclk_pulse();
      sclk_in = 1'b1; idle(4);
      sclk_in = 1'b0; idle(4);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      // 1: reset values
      do_reset();
      chk("rst_time", time_o[0], 16'h1200);
      chk("rst_flags", {13'd0, run_o[0], exp_o[0], buz_o[0]}, 16'h0000);

      // 2: 00:03 counts down and expires on the 0000 edge
      step(1'b0, 1'b0, 1'b1, 16'h0003);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      sclk_pulse(); chk("t2_0002", time_o[0], 16'h0002);
      sclk_pulse(); chk("t2_0001", time_o[0], 16'h0001);
      sclk_pulse(); chk("t2_0000", time_o[0], 16'h0000);
      chk("t2_expired", 16'(exp_o[0]), 16'h1);
      chk("t2_running", 16'(run_o[0]), 16'h0);
      sclk_pulse(); sclk_pulse();
      chk("t2_hold", time_o[0], 16'h0000);

      // 3: triple borrow
      step(1'b0, 1'b0, 1'b1, 16'h1000);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      sclk_pulse(); chk("t3_0959", time_o[0], 16'h0959);

      // 4: prescale by 4 with pause holding the partial second
      step(1'b0, 1'b0, 1'b1, 16'h0100);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      sclk_pulse(); sclk_pulse();
      step(1'b0, 1'b1, 1'b0, 16'h0);
      for (int k = 0; k < 5; k++) sclk_pulse();
      chk("t4_paused", time_o[1], 16'h0100);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      sclk_pulse(); sclk_pulse();
      chk("t4_one_dec", time_o[1], 16'h0059);

      // 5: load beats a coincident tick; start&stop never runs; sanitize
      step(1'b0, 1'b0, 1'b1, 16'h0500);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      sclk_in = 1'b1; idle(3);
      step(1'b0, 1'b0, 1'b1, 16'h0300);
      chk("t5_load_tick", time_o[0], 16'h0300);
      sclk_in = 1'b0; idle(4);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("t5_idle_ss", 16'(run_o[0]), 16'h0);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      step(1'b0, 1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b1, 1'b0, 16'h0);
      chk("t5_pause_ss", 16'(run_o[0]), 16'h0);
      step(1'b0, 1'b0, 1'b1, 16'hFFFF);
      chk("t5_sanitize", time_o[0], 16'h9959);

      // 6: buzzer length on expiry
      step(1'b0, 1'b0, 1'b1, 16'h0001);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      bz_high0 = 0;
      sclk_pulse(); idle(16);
      chk("t6_buzz_len", 16'(bz_high0), BUZZ_ON ? 16'd8 : 16'd0);

      // async reset while running
      step(1'b0, 1'b0, 1'b1, 16'h0200);
      step(1'b1, 1'b0, 1'b0, 16'h0);
      sclk_pulse();
      do_reset();
      chk("rst_mid_run", time_o[0], 16'h1200);

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         logic [15:0] v;
         if ($urandom_range(0, 3) == 0) sclk_in = ~sclk_in;
         v = 16'($urandom);
         if ($urandom_range(0, 1) == 1) v = 16'($urandom_range(0, 3));
         step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 63) == 0, v);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
